// File: rtl/nsa_pkg.sv
// nsa_pkg
//   Shared definitions for the nibble-serial adder: slice width and the
//   controller state type. Imported by nibble_add and nibble_serial_adder.
package nsa_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } nsa_state_t;

    // Index width for a nibble counter; never narrower than one bit.
    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/nibble_add.sv
// nibble_add
//   Combinational 4-bit carry adder slice: {co, s} = x + y + ci.
// Ports
//   x, y  in   NIBBLE_W  addend nibbles
//   ci    in   1         carry-in
//   s     out  NIBBLE_W  sum nibble
//   co    out  1         carry-out
module nibble_add
    import nsa_pkg::*;
(
    input  logic [NIBBLE_W-1:0] x,
    input  logic [NIBBLE_W-1:0] y,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co
);

    always_comb begin
        {co, s} = {1'b0, x} + {1'b0, y} + {{NIBBLE_W{1'b0}}, ci};
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Wide adder that pushes two NIBBLES*4-bit operands through a single
//   nibble_add slice, least-significant nibble first, one nibble per clock,
//   rippling the carry through a register. Operands arrive and the result
//   leaves over independent valid/ready handshakes.
// Ports
//   clk        in   1  clock, all state on rising edge
//   rst        in   1  synchronous active-high reset
//   in_valid   in   1  a/b/cin valid
//   in_ready   out  1  operands can be accepted (IDLE only)
//   a, b       in   W  operands
//   cin        in   1  carry-in to nibble 0
//   out_valid  out  1  sum/cout valid (DONE only)
//   out_ready  in   1  consumer takes the result
//   sum        out  W  result
//   cout       out  1  carry-out of the top nibble
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for operands; last result still visible on sum/cout
// RUN   | adding nibble idx, one nibble per clock
// DONE  | result valid and held until out_ready
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0]  a,
    input  logic [NIBBLE_W*NIBBLES-1:0]  b,
    input  logic                         cin,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0]  sum,
    output logic                         cout
);

    localparam int W    = NIBBLE_W * NIBBLES;
    localparam int IDXW = idx_width(NIBBLES);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIBBLES - 1);

    nsa_state_t          state;
    logic [IDXW-1:0]     idx;
    logic                carry;
    logic [W-1:0]        a_q;
    logic [W-1:0]        b_q;
    logic [W-1:0]        sum_q;
    logic                cout_q;

    logic [NIBBLE_W-1:0] x_nib;
    logic [NIBBLE_W-1:0] y_nib;
    logic [NIBBLE_W-1:0] s_nib;
    logic                c_nib;

    // Slice inputs come from the latched operands, so the live a/b ports
    // are don't-care once the accept edge has passed.
    assign x_nib = a_q[idx*NIBBLE_W +: NIBBLE_W];
    assign y_nib = b_q[idx*NIBBLE_W +: NIBBLE_W];

    nibble_add u_slice (
        .x  (x_nib),
        .y  (y_nib),
        .ci (carry),
        .s  (s_nib),
        .co (c_nib)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q    <= a;
                        b_q    <= b;
                        carry  <= cin;
                        idx    <= '0;
                        sum_q  <= '0;
                        cout_q <= 1'b0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    sum_q[idx*NIBBLE_W +: NIBBLE_W] <= s_nib;
                    carry <= c_nib;
                    if (idx == IDX_LAST) begin
                        cout_q <= c_nib;
                        // Park idx at 0 so it never walks past the top nibble.
                        idx    <= '0;
                        state  <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;

    int checks = 0;
    int errors = 0;

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vcin;
        logic [W-1:0] esum;
        logic         ecout;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Called at a negedge with in_ready high; leaves the bench at the
    // negedge after the accepting edge with in_valid dropped.
    task automatic issue(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci);
        a = ai; b = bi; cin = ci; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    endtask

    // Waits for out_valid, checking in_ready stays low; returns latency.
    task automatic wait_done(input string name, input bit toggle_in, output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            chk({name, "_busy_in_ready"}, 32'(in_ready), 32'd0);
            if (toggle_in) begin
                in_valid = 1'($urandom);
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        chk({name, "_latency"}, 32'(lat), 32'(N));
    endtask

    initial begin
        int lat;
        logic [W:0] expq[$];
        logic [W:0] exp_full;
        logic [W:0] got_full;
        int sent, rcvd, cyc;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum",       32'(sum),       32'd0);
        chk("rst_cout",      32'(cout),      32'd0);

        // Table-driven single operations, out_ready held high.
        vecs[0] = '{16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1};
        vecs[1] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
        for (int i = 0; i < 7; i++) begin
            issue(vecs[i].va, vecs[i].vb, vecs[i].vcin);
            wait_done("vec", 1'b0, lat);
            chk("vec_sum",  32'(sum),  32'(vecs[i].esum));
            chk("vec_cout", 32'(cout), 32'(vecs[i].ecout));
            chk("vec_done_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
            chk("vec_back_idle_in_ready", 32'(in_ready),  32'd1);
            chk("vec_back_idle_out_valid", 32'(out_valid), 32'd0);
            chk("vec_idle_hold_sum", 32'(sum), 32'(vecs[i].esum));
        end

        // Result held through consumer back-pressure.
        out_ready = 1'b0;
        issue(16'hFFFF, 16'h0001, 1'b0);
        wait_done("bp", 1'b0, lat);
        for (int i = 0; i < 3; i++) begin
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_sum",       32'(sum),       32'h0000);
            chk("bp_cout",      32'(cout),      32'd1);
            @(negedge clk);
        end
        chk("bp_4th_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_after_in_ready",  32'(in_ready),  32'd1);
        chk("bp_after_out_valid", 32'(out_valid), 32'd0);

        // Reset two cycles into RUN abandons the operation.
        issue(16'h7777, 16'h1111, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_sum",       32'(sum),       32'd0);
        chk("midrst_cout",      32'(cout),      32'd0);
        chk("midrst_in_ready",  32'(in_ready),  32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("midrst_no_result", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        issue(16'h0001, 16'h0001, 1'b0);
        wait_done("postrst", 1'b0, lat);
        chk("postrst_sum",  32'(sum),  32'h0002);
        chk("postrst_cout", 32'(cout), 32'd0);
        @(negedge clk);

        // in_valid with fresh operands while busy is ignored.
        out_ready = 1'b0;
        issue(16'h2468, 16'hABCD, 1'b1);
        wait_done("busy", 1'b1, lat);
        in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0;
        @(negedge clk);
        chk("busy_done_sum",  32'(sum),  32'(16'hD036));
        chk("busy_done_cout", 32'(cout), 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("busy_idle_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("busy_no_extra", 32'(out_valid), 32'd0);

        // Random traffic against an arithmetic model with a FIFO of expected sums.
        sent = 0; rcvd = 0; cyc = 0;
        while ((sent < 1000 || rcvd < 1000) && cyc < 60000) begin
            in_valid  = (sent < 1000) && ($urandom_range(3) != 0);
            a         = W'($urandom);
            b         = W'($urandom);
            cin       = 1'($urandom);
            out_ready = ($urandom_range(3) != 0);
            if (in_valid && in_ready) begin
                expq.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin});
                sent++;
            end
            if (out_valid && out_ready) begin
                got_full = {cout, sum};
                if (expq.size() == 0) begin
                    chk("rand_unexpected_result", 32'd1, 32'd0);
                end else begin
                    exp_full = expq.pop_front();
                    chk("rand_sum", 32'(got_full), 32'(exp_full));
                end
                rcvd++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        chk("rand_received", 32'(rcvd), 32'd1000);
        chk("rand_pending",  32'(expq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
